// File: rtl/button_event_pkg.sv
// Shared event codes and per-button FSM state encodings for button_event_ctrl.
package button_event_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } state_t;

   localparam logic [1:0] EVT_PRESS   = 2'd0;
   localparam logic [1:0] EVT_RELEASE = 2'd1;
   localparam logic [1:0] EVT_HOLD    = 2'd2;
   localparam logic [1:0] EVT_REPEAT  = 2'd3;

endpackage

// File: rtl/button_event_fsm.sv
// Per-button edge/long-press FSM; o_gen/o_type are a same-cycle event request.
// BUTTON_EVENT_REPEAT_EN adds periodic REPEAT events while held.
module button_event_fsm
   import button_event_pkg::*;
#(
   parameter int HOLD_CYCLES   = 50000000,
`ifdef BUTTON_EVENT_REPEAT_EN
   parameter int REPEAT_CYCLES = 10000000,
`endif
   parameter int CNT_WIDTH     = 26
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_btn,
   output logic       o_gen,
   output logic [1:0] o_type
);

   state_t               r_state;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH:0]   w_cnt_inc;
   logic                 w_hold_hit;
   logic                 w_gen;
   logic [1:0]           w_type;

   // One extra bit so cnt+1 can never wrap below the threshold.
   assign w_cnt_inc  = {1'b0, r_cnt} + (CNT_WIDTH+1)'(1);
   assign w_hold_hit = (w_cnt_inc >= (CNT_WIDTH+1)'(HOLD_CYCLES));

`ifdef BUTTON_EVENT_REPEAT_EN
   logic w_rep_hit;
   assign w_rep_hit = (w_cnt_inc >= (CNT_WIDTH+1)'(REPEAT_CYCLES));
`endif

   always_comb begin
      w_gen  = 1'b0;
      w_type = EVT_PRESS;
      case (r_state)
         ST_IDLE: begin
            if (i_btn) begin
               w_gen  = 1'b1;
               w_type = EVT_PRESS;
            end
         end
         ST_PRESSED: begin
            if (!i_btn) begin
               w_gen  = 1'b1;
               w_type = EVT_RELEASE;
            end else if (w_hold_hit) begin
               w_gen  = 1'b1;
               w_type = EVT_HOLD;
            end
         end
         ST_HELD: begin
            if (!i_btn) begin
               w_gen  = 1'b1;
               w_type = EVT_RELEASE;
            end
`ifdef BUTTON_EVENT_REPEAT_EN
            else if (w_rep_hit) begin
               w_gen  = 1'b1;
               w_type = EVT_REPEAT;
            end
`endif
         end
         default: begin
            w_gen  = 1'b0;
            w_type = EVT_PRESS;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_btn) begin
                  r_state <= ST_PRESSED;
                  r_cnt   <= '0;
               end
            end
            ST_PRESSED: begin
               if (!i_btn) begin
                  r_state <= ST_IDLE;
               end else if (w_hold_hit) begin
                  r_state <= ST_HELD;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= w_cnt_inc[CNT_WIDTH-1:0];
               end
            end
            ST_HELD: begin
               if (!i_btn) begin
                  r_state <= ST_IDLE;
               end
`ifdef BUTTON_EVENT_REPEAT_EN
               else if (w_rep_hit) begin
                  r_cnt <= '0;
               end else begin
                  r_cnt <= w_cnt_inc[CNT_WIDTH-1:0];
               end
`endif
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_gen  = w_gen;
   assign o_type = w_type;

endmodule

// File: rtl/button_event_ctrl.sv
// Serialises per-button PRESS/RELEASE/HOLD/REPEAT events onto one valid/ready stream
// via one-deep pending slots and a round-robin arbiter. BUTTON_EVENT_REPEAT_EN enables REPEAT.
module button_event_ctrl
   import button_event_pkg::*;
#(
   parameter int NUM_BUTTONS   = 4,
   parameter int ID_WIDTH      = 2,
   parameter int HOLD_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000,
   parameter int CNT_WIDTH     = 26
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [NUM_BUTTONS-1:0] i_btn_db,
   output logic                   o_event_valid,
   input  logic                   i_event_ready,
   output logic [ID_WIDTH-1:0]    o_event_id,
   output logic [1:0]             o_event_type,
   output logic                   o_event_dropped
);

   if ((2**ID_WIDTH < NUM_BUTTONS) || (HOLD_CYCLES >= 2**CNT_WIDTH) ||
       (REPEAT_CYCLES >= 2**CNT_WIDTH)) begin : g_bad_cfg
      $error("button_event_ctrl: invalid parameter set");
   end

   logic [NUM_BUTTONS-1:0] w_gen;
   logic [NUM_BUTTONS-1:0] w_consume;
   logic [NUM_BUTTONS-1:0] w_drop;
   logic [1:0]             w_gen_type [NUM_BUTTONS];
   logic [NUM_BUTTONS-1:0] r_slot_vld;
   logic [1:0]             r_slot_type [NUM_BUTTONS];
   logic                   r_evt_vld;
   logic [ID_WIDTH-1:0]    r_evt_id;
   logic [1:0]             r_evt_type;
   logic                   r_dropped;
   logic [ID_WIDTH-1:0]    r_ptr;
   logic                   w_load;
   logic                   w_found;
   logic [ID_WIDTH-1:0]    w_win;
   logic [ID_WIDTH-1:0]    w_scan;
   int                     w_sum;

   assign w_load = !r_evt_vld || i_event_ready;

   for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
      button_event_fsm #(
         .HOLD_CYCLES   (HOLD_CYCLES),
`ifdef BUTTON_EVENT_REPEAT_EN
         .REPEAT_CYCLES (REPEAT_CYCLES),
`endif
         .CNT_WIDTH     (CNT_WIDTH)
      ) u_fsm (
         .i_clk  (i_clk),
         .i_rst  (i_rst),
         .i_btn  (i_btn_db[gi]),
         .o_gen  (w_gen[gi]),
         .o_type (w_gen_type[gi])
      );
      assign w_consume[gi] = w_load && w_found && (w_win == ID_WIDTH'(gi));
   end

   // A fresh event is lost only when its slot stays occupied this cycle.
   assign w_drop = w_gen & r_slot_vld & ~w_consume;

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_scan  = '0;
      w_sum   = 0;
      for (int k = 0; k < NUM_BUTTONS; k++) begin
         w_sum = int'(r_ptr) + k;
         if (w_sum >= NUM_BUTTONS) w_sum = w_sum - NUM_BUTTONS;
         w_scan = ID_WIDTH'(w_sum);
         if (!w_found && r_slot_vld[w_scan]) begin
            w_found = 1'b1;
            w_win   = w_scan;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_slot_vld <= '0;
         for (int i = 0; i < NUM_BUTTONS; i++) r_slot_type[i] <= EVT_PRESS;
      end else begin
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (w_gen[i] && !w_drop[i]) begin
               r_slot_vld[i]  <= 1'b1;
               r_slot_type[i] <= w_gen_type[i];
            end else if (w_consume[i]) begin
               r_slot_vld[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_evt_vld  <= 1'b0;
         r_evt_id   <= '0;
         r_evt_type <= EVT_PRESS;
         r_dropped  <= 1'b0;
         r_ptr      <= '0;
      end else begin
         r_dropped <= |w_drop;
         if (w_load) begin
            r_evt_vld <= w_found;
            if (w_found) begin
               r_evt_id   <= w_win;
               r_evt_type <= r_slot_type[w_win];
               r_ptr      <= (w_win == ID_WIDTH'(NUM_BUTTONS-1)) ? '0 : w_win + ID_WIDTH'(1);
            end
         end
      end
   end

   assign o_event_valid   = r_evt_vld;
   assign o_event_id      = r_evt_id;
   assign o_event_type    = r_evt_type;
   assign o_event_dropped = r_dropped;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with HOLD=8, REPEAT=4; expectations follow BUTTON_EVENT_REPEAT_EN.
module tb_button_event_ctrl;
   import button_event_pkg::*;

   logic       clk;
   logic       rst;
   logic [3:0] btn_db;
   logic       ev_valid;
   logic       ev_ready;
   logic [1:0] ev_id;
   logic [1:0] ev_type;
   logic       ev_dropped;

   int         n_vec;
   int         n_err;
   logic       exp_v;
   logic [1:0] exp_t;

   button_event_ctrl #(
      .NUM_BUTTONS   (4),
      .ID_WIDTH      (2),
      .HOLD_CYCLES   (8),
      .REPEAT_CYCLES (4),
      .CNT_WIDTH     (4)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_btn_db        (btn_db),
      .o_event_valid   (ev_valid),
      .i_event_ready   (ev_ready),
      .o_event_id      (ev_id),
      .o_event_type    (ev_type),
      .o_event_dropped (ev_dropped)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic ev, input logic [1:0] eid,
                      input logic [1:0] ety, input logic edrop);
      n_vec++;
      assert (ev_valid === ev && ev_dropped === edrop &&
              (!ev || (ev_id === eid && ev_type === ety)))
      else begin
         n_err++;
         $error("FAIL %s: got vld=%b id=%0d type=%0d drop=%b, want vld=%b id=%0d type=%0d drop=%b",
                tag, ev_valid, ev_id, ev_type, ev_dropped, ev, eid, ety, edrop);
      end
   endtask

   task automatic chk_zero(input string tag);
      n_vec++;
      assert ({ev_valid, ev_id, ev_type, ev_dropped} === 6'b0)
      else begin
         n_err++;
         $error("FAIL %s: got vld=%b id=%0d type=%0d drop=%b, want all zero",
                tag, ev_valid, ev_id, ev_type, ev_dropped);
      end
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst      = 1'b1;
      btn_db   = 4'b0000;
      ev_ready = 1'b1;
      tick();
      tick();
      chk_zero("reset");
      rst = 1'b0;

      // Single tap on button 1
      btn_db = 4'b0010;
      tick(); chk("tap_e1", 1'b0, 2'd0, EVT_PRESS, 1'b0);
      tick(); chk("tap_press", 1'b1, 2'd1, EVT_PRESS, 1'b0);
      tick(); chk("tap_e3", 1'b0, 2'd0, EVT_PRESS, 1'b0);
      btn_db = 4'b0000;
      tick(); chk("tap_e4", 1'b0, 2'd0, EVT_PRESS, 1'b0);
      tick(); chk("tap_release", 1'b1, 2'd1, EVT_RELEASE, 1'b0);
      tick(); chk("tap_e6", 1'b0, 2'd0, EVT_PRESS, 1'b0);

      // Long press on button 0 for 20 cycles; release collides with a repeat expiry
      btn_db = 4'b0001;
      for (int e = 1; e <= 23; e++) begin
         tick();
         exp_v = 1'b0;
         exp_t = EVT_PRESS;
         if (e == 2) begin
            exp_v = 1'b1; exp_t = EVT_PRESS;
         end else if (e == 10) begin
            exp_v = 1'b1; exp_t = EVT_HOLD;
         end else if (e == 22) begin
            exp_v = 1'b1; exp_t = EVT_RELEASE;
         end
`ifdef BUTTON_EVENT_REPEAT_EN
         else if (e == 14 || e == 18) begin
            exp_v = 1'b1; exp_t = EVT_REPEAT;
         end
`endif
         chk($sformatf("hold_e%0d", e), exp_v, 2'd0, exp_t, 1'b0);
         if (e == 20) btn_db = 4'b0000;
      end

      // Fairness from pointer 0
      rst = 1'b1;
      tick(); chk_zero("rst_pulse");
      rst = 1'b0;
      btn_db = 4'b1111;
      tick(); chk("fair0_e1", 1'b0, 2'd0, EVT_PRESS, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick(); chk($sformatf("fair0_press%0d", k), 1'b1, 2'(k), EVT_PRESS, 1'b0);
      end
      btn_db = 4'b0000;
      tick(); chk("fair0_gap", 1'b0, 2'd0, EVT_PRESS, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick(); chk($sformatf("fair0_rel%0d", k), 1'b1, 2'(k), EVT_RELEASE, 1'b0);
      end
      tick(); chk("fair0_idle", 1'b0, 2'd0, EVT_PRESS, 1'b0);

      // One-cycle tap of button 1 moves the pointer to 2
      btn_db = 4'b0010;
      tick();
      btn_db = 4'b0000;
      tick(); chk("ptr_press", 1'b1, 2'd1, EVT_PRESS, 1'b0);
      tick(); chk("ptr_release", 1'b1, 2'd1, EVT_RELEASE, 1'b0);
      tick(); chk("ptr_idle", 1'b0, 2'd0, EVT_PRESS, 1'b0);

      // Fairness from pointer 2
      btn_db = 4'b1111;
      tick(); chk("fair2_e1", 1'b0, 2'd0, EVT_PRESS, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick(); chk($sformatf("fair2_press%0d", k), 1'b1, 2'((2 + k) % 4), EVT_PRESS, 1'b0);
      end
      btn_db = 4'b0000;
      tick(); chk("fair2_gap", 1'b0, 2'd0, EVT_PRESS, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick(); chk($sformatf("fair2_rel%0d", k), 1'b1, 2'((2 + k) % 4), EVT_RELEASE, 1'b0);
      end
      tick(); chk("fair2_idle", 1'b0, 2'd0, EVT_PRESS, 1'b0);

      // Backpressure: output stalls for 10 cycles, full slots drop new events
      ev_ready = 1'b0;
      btn_db = 4'b0100;
      tick(); chk("bp_e1", 1'b0, 2'd0, EVT_PRESS, 1'b0);
      tick(); chk("bp_e2", 1'b1, 2'd2, EVT_PRESS, 1'b0);
      btn_db = 4'b0000;
      tick(); chk("bp_e3_refill", 1'b1, 2'd2, EVT_PRESS, 1'b0);
      btn_db = 4'b0100;
      tick(); chk("bp_e4_drop", 1'b1, 2'd2, EVT_PRESS, 1'b1);
      tick(); chk("bp_e5", 1'b1, 2'd2, EVT_PRESS, 1'b0);
      btn_db = 4'b0000;
      tick(); chk("bp_e6_drop", 1'b1, 2'd2, EVT_PRESS, 1'b1);
      tick(); chk("bp_e7", 1'b1, 2'd2, EVT_PRESS, 1'b0);
      btn_db = 4'b1000;
      tick(); chk("bp_e8_slot3", 1'b1, 2'd2, EVT_PRESS, 1'b0);
      btn_db = 4'b0000;
      tick(); chk("bp_e9_drop", 1'b1, 2'd2, EVT_PRESS, 1'b1);
      tick(); chk("bp_e10", 1'b1, 2'd2, EVT_PRESS, 1'b0);
      ev_ready = 1'b1;
      tick(); chk("bp_drain3", 1'b1, 2'd3, EVT_PRESS, 1'b0);
      tick(); chk("bp_drain2", 1'b1, 2'd2, EVT_RELEASE, 1'b0);
      tick(); chk("bp_idle", 1'b0, 2'd0, EVT_PRESS, 1'b0);

      // Slot 2 consumed in the same cycle its RELEASE is generated
      ev_ready = 1'b0;
      btn_db = 4'b0101;
      tick(); chk("sim_e1", 1'b0, 2'd0, EVT_PRESS, 1'b0);
      tick(); chk("sim_e2", 1'b1, 2'd0, EVT_PRESS, 1'b0);
      btn_db = 4'b0000;
      ev_ready = 1'b1;
      tick(); chk("sim_e3", 1'b1, 2'd2, EVT_PRESS, 1'b0);
      tick(); chk("sim_e4", 1'b1, 2'd0, EVT_RELEASE, 1'b0);
      tick(); chk("sim_e5", 1'b1, 2'd2, EVT_RELEASE, 1'b0);
      tick(); chk("sim_idle", 1'b0, 2'd0, EVT_PRESS, 1'b0);

      // Reset while button 3 is in HELD
      btn_db = 4'b1000;
      for (int e = 1; e <= 10; e++) begin
         tick();
         exp_v = (e == 2 || e == 10);
         exp_t = (e == 10) ? EVT_HOLD : EVT_PRESS;
         chk($sformatf("rh_e%0d", e), exp_v, 2'd3, exp_t, 1'b0);
      end
      rst = 1'b1;
      tick(); chk_zero("rh_reset");
      rst = 1'b0;
      tick(); chk("rh_post1", 1'b0, 2'd0, EVT_PRESS, 1'b0);
      tick(); chk("rh_press", 1'b1, 2'd3, EVT_PRESS, 1'b0);
      btn_db = 4'b0000;
      tick(); chk("rh_gap", 1'b0, 2'd0, EVT_PRESS, 1'b0);
      tick(); chk("rh_release", 1'b1, 2'd3, EVT_RELEASE, 1'b0);
      tick(); chk("rh_idle", 1'b0, 2'd0, EVT_PRESS, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
- Sequences the per-bit outputs of the team's debouncer into discrete button events: PRESS, RELEASE, HOLD and REPEAT.
- Per-button FSMs detect edges and long presses. A round-robin scheduler then serialises all buttons' events onto one valid/ready event stream.
- Sits between the debouncer outputs and the UI/menu logic, for example the mode and reset controls of the estimator display.

Parameters:
- NUM_BUTTONS, 4: number of debounced inputs.
- ID_WIDTH, 2: width of event_id. Must satisfy 2**ID_WIDTH >= NUM_BUTTONS.
- HOLD_CYCLES, 50000000: cycles a button must stay pressed before the HOLD event.
- REPEAT_CYCLES, 10000000: cycles between REPEAT events while held.
- CNT_WIDTH, 26: per-button counter width. Must hold max(HOLD_CYCLES, REPEAT_CYCLES).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_db  in  NUM_BUTTONS  debounced button levels, 1 = pressed
- event_valid  out  1  event available
- event_ready  in  1  consumer accepts the event
- event_id  out  ID_WIDTH  index of the button that produced the event
- event_type  out  2  event code: 0 PRESS, 1 RELEASE, 2 HOLD, 3 REPEAT
- event_dropped  out  1  one-cycle pulse when an event is lost

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is synchronous and active-high, rst.
- Reset values: all FSMs IDLE, counters 0, pending slots empty, event_valid 0, event_id 0, event_type 0, event_dropped 0, round-robin pointer 0.
- rst asserted mid-operation: everything returns to reset state on the next edge. In-flight and pending events are discarded with no event_dropped pulse. A button held through reset generates PRESS after rst deasserts.
- Per-button FSM, with cnt meaning the per-button counter:
  - IDLE: btn=1 → PRESSED, cnt=0, generate PRESS.
  - PRESSED: btn=0 → IDLE, generate RELEASE. Else if cnt+1 >= HOLD_CYCLES → HELD, cnt=0, generate HOLD. Else cnt++.
  - HELD: btn=0 → IDLE, generate RELEASE. With REPEAT: see Optional Feature.
  - Release has priority over a hold or repeat expiry in the same cycle.
- Compare cnt+1 at CNT_WIDTH+1 bits so the comparison never wraps.
- Pending slot, one per button (valid bit plus 2-bit type):
  - A generated event is written into the slot at the next edge.
  - If the slot is occupied and not being consumed that cycle, the new event is dropped. The slot keeps the old event, and event_dropped pulses for 1 cycle.
  - If the slot is consumed in the same cycle a new event is generated, the new event fills the slot and nothing is dropped.
- Output register:
  - Loads when event_valid=0, or when event_valid && event_ready.
  - The source is the first occupied slot, searching from the round-robin pointer upward with wrap.
  - The pointer becomes winner+1, modulo NUM_BUTTONS.
  - If no slot is occupied, event_valid falls to 0 after the handshake.
- Handshake rules:
  - While event_valid && !event_ready, event_id and event_type hold stable.
  - event_valid never drops without a handshake, except on rst.
- Latency: button edge sampled at cycle t → pending at t+1 → event_valid at t+2 when the output is free.
- Throughput: 1 event per cycle with event_ready tied high.

Optional Feature:
- Macro: BUTTON_EVENT_REPEAT_EN.
- Defined: in HELD, when cnt+1 >= REPEAT_CYCLES, set cnt=0 and generate REPEAT. Otherwise cnt++. Repeats continue until release.
- Undefined: HELD only waits for release. cnt is frozen, type 3 is never produced, and the REPEAT comparison logic is absent.

Decomposition:
- Package button_event_pkg:
  - Event type constants EVT_PRESS=2'd0, EVT_RELEASE=2'd1, EVT_HOLD=2'd2, EVT_REPEAT=2'd3.
  - FSM state encodings ST_IDLE, ST_PRESSED, ST_HELD.
- Sub-module button_event_fsm: one instance per button, holding the FSM, counter and event generation (gen pulse plus type).
- The top level holds the pending slots, the round-robin arbiter and the output register.

Test Plan (NUM_BUTTONS=4, HOLD_CYCLES=8, REPEAT_CYCLES=4, event_ready=1 unless stated):
- Single tap: btn_db[1] high for 3 cycles, then low → PRESS id=1 at t+2, RELEASE id=1. No HOLD; event_dropped never set.
- Hold, macro defined: btn_db[0] high for 20 cycles → PRESS, then HOLD 8 cycles after PRESS, then REPEATs 4 cycles apart, then RELEASE. With the macro undefined: PRESS, HOLD, RELEASE only.
- Fairness: btn_db = 4'b1111 in one cycle → four PRESS events on consecutive cycles with ids 0,1,2,3. A repeat with the pointer starting at 2 gives order 2,3,0,1.
- Backpressure: event_ready=0 for 10 cycles with a PRESS pending → event_valid stays 1 with id and type stable. A second event is dropped only if that button's slot is already full; dropped exactly once per lost event.
- Simultaneous consume and generate: slot 2 consumed in the same cycle its RELEASE is generated → RELEASE delivered, no drop.
- Reset mid-hold: rst asserted for 1 cycle while btn_db[3] is held in HELD → outputs return to 0. PRESS id=3 appears 2 cycles after rst deasserts.
